button_gesture: RTL and testbench

BUTTON_GESTURE -- requirements
Module: button_gesture

---
 rtl/button_gesture.sv | 165 ++++++++++++++++
 tb/tb_button_gesture.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_gesture.sv
// Push-button gesture classifier: synchronizes and debounces an active-low
// button, measures press length and reports short, medium, long and
// double-click gestures as single-cycle events.
module button_gesture #(
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned MED_CYC      = 100000000,
    parameter int unsigned LONG_CYC     = 250000000,
    parameter int unsigned DBL_GAP_CYC  = 25000000
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        button,
    output logic        pressed,
    output logic        evt_valid,
    output logic [2:0]  evt_code,
    output logic [31:0] press_len
);

    localparam int unsigned CNT_W = 32;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] MED_LEN  = CNT_W'(MED_CYC);
    localparam logic [CNT_W-1:0] LONG_LEN = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0] GAP_MAX  = CNT_W'(DBL_GAP_CYC);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    localparam logic [2:0] CODE_NONE   = 3'b000;
    localparam logic [2:0] CODE_SHORT  = 3'b001;
    localparam logic [2:0] CODE_MEDIUM = 3'b010;
    localparam logic [2:0] CODE_LONG   = 3'b011;
    localparam logic [2:0] CODE_DOUBLE = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS1 = 2'd1,
        GAP    = 2'd2,
        PRESS2 = 2'd3
    } state_t;

    logic [1:0]       sync_q;
    logic             btn_sync;
    logic [CNT_W-1:0] db_cnt;
    logic             pressed_d;
    logic             press_edge_c;
    logic             rel_edge_c;
    logic [CNT_W-1:0] press_cnt;
    logic [CNT_W-1:0] gap_cnt;
    state_t           state;

    // Two-flop synchronizer; stores the inverted pin so 1 means held
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], ~button};
        end
    end

    assign btn_sync = sync_q[1];

    // Debounce: level flips only after DEBOUNCE_CYC consecutive differing cycles
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            db_cnt  <= '0;
            pressed <= 1'b0;
        end else if (btn_sync != pressed) begin
            if (db_cnt == DB_LAST) begin
                pressed <= ~pressed;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Delayed debounced level for edge detection
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pressed_d <= 1'b0;
        end else begin
            pressed_d <= pressed;
        end
    end

    assign press_edge_c = pressed & ~pressed_d;
    assign rel_edge_c   = ~pressed & pressed_d;

    // Press length counter; the edge cycle is the first held cycle, so it restarts at 1
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            press_cnt <= '0;
            press_len <= '0;
        end else begin
            if (press_edge_c) begin
                press_cnt <= CNT_W'(1);
            end else if (pressed && (press_cnt != CNT_SAT)) begin
                press_cnt <= press_cnt + CNT_W'(1);
            end
            if (rel_edge_c) begin
                press_len <= press_cnt;
            end
        end
    end

    // Gesture FSM with registered single-cycle event outputs
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            evt_valid <= 1'b0;
            evt_code  <= CODE_NONE;
        end else begin
            evt_valid <= 1'b0;
            evt_code  <= CODE_NONE;
            case (state)
                IDLE: begin
                    if (press_edge_c) begin
                        state <= PRESS1;
                    end
                end
                PRESS1: begin
                    if (rel_edge_c) begin
                        if (press_cnt >= LONG_LEN) begin
                            evt_valid <= 1'b1;
                            evt_code  <= CODE_LONG;
                            state     <= IDLE;
                        end else if (press_cnt >= MED_LEN) begin
                            evt_valid <= 1'b1;
                            evt_code  <= CODE_MEDIUM;
                            state     <= IDLE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    // A press in the timeout cycle still counts as the second click
                    if (press_edge_c) begin
                        state <= PRESS2;
                    end else if (gap_cnt >= GAP_MAX) begin
                        evt_valid <= 1'b1;
                        evt_code  <= CODE_SHORT;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + CNT_W'(1);
                    end
                end
                PRESS2: begin
                    if (rel_edge_c) begin
                        evt_valid <= 1'b1;
                        evt_code  <= CODE_DOUBLE;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_gesture.sv
// Bench for button_gesture: table of single presses, directed corner-case
// sequences and randomized button activity against a gesture-level model.
module tb_button_gesture;

    localparam int unsigned DB   = 4;
    localparam int unsigned MED  = 20;
    localparam int unsigned LONG = 40;
    localparam int unsigned GAP  = 10;

    logic        pclk = 1'b0;
    logic        rst;
    logic        button;
    logic        pressed;
    logic        evt_valid;
    logic [2:0]  evt_code;
    logic [31:0] press_len;

    button_gesture #(
        .DEBOUNCE_CYC (DB),
        .MED_CYC      (MED),
        .LONG_CYC     (LONG),
        .DBL_GAP_CYC  (GAP)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .button    (button),
        .pressed   (pressed),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .press_len (press_len)
    );

    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b1;
    bit saw_pressed;
    logic [2:0] ev_codes[$];

    // Reference model state: synchronized/debounced level plus gesture bookkeeping
    logic        m_s1, m_s2, m_lvl, m_prev;
    int unsigned m_run;
    logic [31:0] m_hold, m_len;
    bit          m_pend, m_dbl;
    int unsigned m_age;
    logic        m_ev_valid;
    logic [2:0]  m_ev_code;

    typedef struct {
        int          low;
        int          high;
        logic [2:0]  code;
        logic [31:0] len;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_prev = 1'b0;
        m_run = 0; m_hold = '0; m_len = '0;
        m_pend = 1'b0; m_dbl = 1'b0; m_age = 0;
        m_ev_valid = 1'b0; m_ev_code = 3'b000;
    endtask

    task automatic emit(input logic [2:0] code);
        m_ev_valid = 1'b1;
        m_ev_code  = code;
    endtask

    // One clock of the gesture model, working from the previous debounced level
    task automatic model_clock();
        logic l_old, p_old, s2_old;
        l_old  = m_lvl;
        p_old  = m_prev;
        s2_old = m_s2;
        m_ev_valid = 1'b0;
        m_ev_code  = 3'b000;
        if (m_pend) m_age++;
        if (l_old && !p_old) begin
            m_hold = 32'd1;
            if (m_pend) begin
                m_pend = 1'b0;
                m_dbl  = 1'b1;
            end
        end else if (m_pend && (m_age == GAP + 1)) begin
            m_pend = 1'b0;
            emit(3'b001);
        end
        if (l_old && p_old && (m_hold != 32'hFFFF_FFFF)) m_hold = m_hold + 32'd1;
        if (!l_old && p_old) begin
            m_len = m_hold;
            if (m_dbl) begin
                m_dbl = 1'b0;
                emit(3'b100);
            end else if (m_hold >= LONG) begin
                emit(3'b011);
            end else if (m_hold >= MED) begin
                emit(3'b010);
            end else begin
                m_pend = 1'b1;
                m_age  = 0;
            end
        end
        if (s2_old != l_old) begin
            m_run++;
            if (m_run == DB) begin
                m_lvl = ~l_old;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_prev = l_old;
        m_s2   = m_s1;
        m_s1   = ~button;
    endtask

    task automatic step();
        @(posedge pclk);
        if (rst) model_reset();
        else model_clock();
        #1;
        if (evt_valid) ev_codes.push_back(evt_code);
        if (pressed) saw_pressed = 1'b1;
        if (chk_en) begin
            check("model pressed", 32'(pressed), 32'(m_lvl));
            check("model evt_valid", 32'(evt_valid), 32'(m_ev_valid));
            check("model evt_code", 32'(evt_code), 32'(m_ev_code));
            check("model press_len", press_len, m_len);
        end
    endtask

    task automatic run(input logic b, input int n);
        button = b;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [2:0] got;
        int n_dbl;

        vecs[0] = '{10, 30, 3'b001, 32'd10};
        vecs[1] = '{20, 30, 3'b010, 32'd20};
        vecs[2] = '{45, 30, 3'b011, 32'd45};
        vecs[3] = '{19, 30, 3'b001, 32'd19};
        vecs[4] = '{39, 30, 3'b010, 32'd39};
        vecs[5] = '{40, 30, 3'b011, 32'd40};
        vecs[6] = '{4,  30, 3'b001, 32'd4};
        vecs[7] = '{25, 30, 3'b010, 32'd25};

        model_reset();
        rst    = 1'b1;
        button = 1'b1;
        run(1'b1, 3);
        check("reset pressed", 32'(pressed), 32'd0);
        check("reset evt_valid", 32'(evt_valid), 32'd0);
        check("reset evt_code", 32'(evt_code), 32'd0);
        check("reset press_len", press_len, 32'd0);
        rst = 1'b0;
        run(1'b1, 5);

        // Single presses, each followed by a long release
        for (int v = 0; v < 8; v++) begin
            ev_codes.delete();
            run(1'b0, vecs[v].low);
            run(1'b1, vecs[v].high);
            got = (ev_codes.size() > 0) ? ev_codes[0] : 3'b111;
            check($sformatf("vec%0d event count", v), 32'(ev_codes.size()), 32'd1);
            check($sformatf("vec%0d code", v), 32'(got), 32'(vecs[v].code));
            check($sformatf("vec%0d press_len", v), press_len, vecs[v].len);
        end

        // Sub-debounce glitches must leave pressed low and emit nothing
        ev_codes.delete();
        saw_pressed = 1'b0;
        for (int g = 0; g < 5; g++) begin
            run(1'b0, 3);
            run(1'b1, 6);
        end
        run(1'b1, 20);
        check("glitch pressed", 32'(saw_pressed), 32'd0);
        check("glitch events", 32'(ev_codes.size()), 32'd0);

        // Two short presses with a short gap form one double click
        ev_codes.delete();
        run(1'b0, 8); run(1'b1, 6); run(1'b0, 8); run(1'b1, 30);
        got = (ev_codes.size() > 0) ? ev_codes[0] : 3'b111;
        check("double count", 32'(ev_codes.size()), 32'd1);
        check("double code", 32'(got), 32'd4);

        // A long gap yields two independent short events
        ev_codes.delete();
        run(1'b0, 8); run(1'b1, 15); run(1'b0, 8); run(1'b1, 30);
        check("gap15 count", 32'(ev_codes.size()), 32'd2);
        got = (ev_codes.size() > 0) ? ev_codes[0] : 3'b111;
        check("gap15 first", 32'(got), 32'd1);
        got = (ev_codes.size() > 1) ? ev_codes[1] : 3'b111;
        check("gap15 second", 32'(got), 32'd1);

        // Reset during the second press discards the gesture
        ev_codes.delete();
        run(1'b0, 8); run(1'b1, 6); run(1'b0, 10);
        rst = 1'b1;
        run(1'b0, 3);
        check("rst pressed", 32'(pressed), 32'd0);
        check("rst evt_valid", 32'(evt_valid), 32'd0);
        check("rst press_len", press_len, 32'd0);
        rst = 1'b0;
        run(1'b0, 5);
        check("post-rst pressed still low", 32'(pressed), 32'd0);
        run(1'b0, 1);
        check("post-rst pressed rises", 32'(pressed), 32'd1);
        run(1'b0, 10);
        run(1'b1, 30);
        n_dbl = 0;
        foreach (ev_codes[k]) if (ev_codes[k] == 3'b100) n_dbl++;
        check("post-rst no double", 32'(n_dbl), 32'd0);
        check("post-rst event count", 32'(ev_codes.size()), 32'd1);
        got = (ev_codes.size() > 0) ? ev_codes[0] : 3'b111;
        check("post-rst code", 32'(got), 32'd1);

        // Saturating press counter, pushed near all-ones
        chk_en = 1'b0;
        ev_codes.delete();
        run(1'b0, 10);
        force dut.press_cnt = 32'hFFFF_FFF0;
        step(); step();
        release dut.press_cnt;
        run(1'b0, 30);
        run(1'b1, 20);
        check("sat press_len", press_len, 32'hFFFF_FFFF);
        got = (ev_codes.size() > 0) ? ev_codes[0] : 3'b111;
        check("sat code", 32'(got), 32'd3);
        rst = 1'b1;
        run(1'b1, 2);
        rst = 1'b0;
        chk_en = 1'b1;
        run(1'b1, 5);

        // Random button activity with occasional resets
        for (int r = 0; r < 120; r++) begin
            run(1'($urandom_range(0, 1)), int'($urandom_range(1, 40)));
            if ($urandom_range(0, 25) == 0) begin
                rst = 1'b1;
                run(button, 2);
                rst = 1'b0;
            end
        end
        run(1'b1, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
